hsid_mc_fifo: RTL

Multi-channel successor of the single-channel HSI FIFO. It holds NUM_CH independent circular buffers sharing one clock, one reset and one almost-full threshold. Each channel has a per-channel loop (replay) mode, a fill level output, a read-valid strobe, and overflow/underflow flags. It sits between the pixel-band streamer and the distance/accumulation datapath, where stored reference spectra are replayed.

---
 rtl/hsid_pkg.sv | 8 +
 rtl/hsid_mc_fifo_ch.sv | 97 +++++++++
 rtl/hsid_mc_fifo.sv | 54 +++++
 3 files changed

// File: rtl/hsid_pkg.sv
// hsid_pkg: shared defaults and types for the HSID FIFO blocks.
package hsid_pkg;
    localparam int HSID_FIFO_NUM_CH     = 4;
    localparam int HSID_FIFO_DATA_WIDTH = 32;
    localparam int HSID_FIFO_DEPTH      = 16;
    localparam int HSID_FIFO_CNT_WIDTH  = $clog2(HSID_FIFO_DEPTH + 1);
    typedef logic [HSID_FIFO_CNT_WIDTH-1:0] hsid_fifo_level_t;
endpackage

// File: rtl/hsid_mc_fifo_ch.sv
// hsid_mc_fifo_ch: one circular FIFO channel with replay (loop) mode.
// Error flags are built only when HSID_MC_FIFO_ERR_EN is defined.
module hsid_mc_fifo_ch
    import hsid_pkg::*;
#(
    parameter int DATA_WIDTH = HSID_FIFO_DATA_WIDTH,
    parameter int FIFO_DEPTH = HSID_FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  loop_en,
    input  logic                  wr_en,
    input  logic                  rd_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [CNT_WIDTH-1:0]  almost_full_threshold,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic [CNT_WIDTH-1:0]  level,
    output logic                  full,
    output logic                  almost_full,
    output logic                  empty,
    output logic                  overflow,
    output logic                  underflow
);
    localparam logic [ADDR_WIDTH-1:0] A1     = 1;
    localparam logic [CNT_WIDTH-1:0]  C1     = 1;
    localparam logic [CNT_WIDTH-1:0]  CDEPTH = CNT_WIDTH'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, lp_ptr_q, lp_ptr_d, lp_inc;
    logic [CNT_WIDTH-1:0]  level_q, level_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q, flush, do_wr, do_rd, lp_rd;

    assign flush       = rst || clear;
    assign full        = level_q == CDEPTH;
    assign empty       = level_q == '0;
    assign almost_full = level_q >= almost_full_threshold;
    assign do_wr       = !loop_en && wr_en && (!full || rd_en);
    assign do_rd       = !loop_en && rd_en && !empty;
    assign lp_rd       = loop_en && rd_en && !empty;
    assign lp_inc      = lp_ptr_q + A1;
    assign data_out    = data_q;
    assign data_valid  = valid_q;
    assign level       = level_q;

    // Outside loop mode the cursor follows the next read pointer so replay starts at the oldest word.
    always_comb begin
        wr_ptr_d = do_wr ? wr_ptr_q + A1 : wr_ptr_q;
        rd_ptr_d = do_rd ? rd_ptr_q + A1 : rd_ptr_q;
        level_d  = (do_wr && !do_rd) ? level_q + C1 : (do_rd && !do_wr) ? level_q - C1 : level_q;
        lp_ptr_d = !loop_en ? rd_ptr_d : !lp_rd ? lp_ptr_q : (lp_inc == wr_ptr_q) ? rd_ptr_q : lp_inc;
    end

    always_ff @(posedge clk) begin
        if (!flush && do_wr) mem_q[wr_ptr_q] <= data_in;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            lp_ptr_q <= '0;
            level_q  <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            lp_ptr_q <= lp_ptr_d;
            level_q  <= level_d;
            valid_q  <= do_rd || lp_rd;
            if (do_rd || lp_rd) data_q <= mem_q[loop_en ? lp_ptr_q : rd_ptr_q];
        end
    end

`ifdef HSID_MC_FIFO_ERR_EN
    logic ovf_q, udf_q;
    always_ff @(posedge clk) begin
        if (flush) begin
            ovf_q <= 1'b0;
            udf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_q || (!loop_en && wr_en && full && !rd_en);
            udf_q <= udf_q || (rd_en && empty);
        end
    end
    assign overflow  = ovf_q;
    assign underflow = udf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule

// File: rtl/hsid_mc_fifo.sv
// hsid_mc_fifo: NUM_CH independent replayable FIFOs sharing clock, reset and almost-full threshold.
// Sticky overflow/underflow flags are enabled with HSID_MC_FIFO_ERR_EN.
module hsid_mc_fifo
    import hsid_pkg::*;
#(
    parameter int NUM_CH     = HSID_FIFO_NUM_CH,
    parameter int DATA_WIDTH = HSID_FIFO_DATA_WIDTH,
    parameter int FIFO_DEPTH = HSID_FIFO_DEPTH,
    parameter int ADDR_WIDTH = $clog2(FIFO_DEPTH),
    parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_CH-1:0]            clear,
    input  logic [NUM_CH-1:0]            loop_en,
    input  logic [NUM_CH-1:0]            wr_en,
    input  logic [NUM_CH-1:0]            rd_en,
    input  logic [NUM_CH*DATA_WIDTH-1:0] data_in,
    input  logic [CNT_WIDTH-1:0]         almost_full_threshold,
    output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
    output logic [NUM_CH-1:0]            data_valid,
    output logic [NUM_CH*CNT_WIDTH-1:0]  level,
    output logic [NUM_CH-1:0]            full,
    output logic [NUM_CH-1:0]            almost_full,
    output logic [NUM_CH-1:0]            empty,
    output logic [NUM_CH-1:0]            overflow,
    output logic [NUM_CH-1:0]            underflow
);
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        hsid_mc_fifo_ch #(
            .DATA_WIDTH(DATA_WIDTH),
            .FIFO_DEPTH(FIFO_DEPTH),
            .ADDR_WIDTH(ADDR_WIDTH),
            .CNT_WIDTH (CNT_WIDTH)
        ) u_ch (
            .clk                  (clk),
            .rst                  (rst),
            .clear                (clear[c]),
            .loop_en              (loop_en[c]),
            .wr_en                (wr_en[c]),
            .rd_en                (rd_en[c]),
            .data_in              (data_in[c*DATA_WIDTH +: DATA_WIDTH]),
            .almost_full_threshold(almost_full_threshold),
            .data_out             (data_out[c*DATA_WIDTH +: DATA_WIDTH]),
            .data_valid           (data_valid[c]),
            .level                (level[c*CNT_WIDTH +: CNT_WIDTH]),
            .full                 (full[c]),
            .almost_full          (almost_full[c]),
            .empty                (empty[c]),
            .overflow             (overflow[c]),
            .underflow            (underflow[c])
        );
    end
endmodule
